// File: rtl/imem_arb_if.sv
// imem_arb_if: request/response and memory-side signals of the two-port
// instruction-memory read arbiter. "slave" is the arbiter's view; "master"
// is the view of whatever drives the requesters and models the memory.
`timescale 1ns/1ps
interface imem_arb_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_addr0;
  logic [WIDTH-1:0] req_addr1;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic [WIDTH-1:0] rsp_data0;
  logic [WIDTH-1:0] rsp_data1;
  logic [1:0]       rsp_err;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_rd_en;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_addr0, req_addr1, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_err,
           mem_addr, mem_rd_en
  );

  modport master (
    output req_valid, req_addr0, req_addr1, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_err,
           mem_addr, mem_rd_en
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction memory between the fetch stage
// (port 0) and the debug/trace reader (port 1). One grant per cycle,
// byte address -> word index, responses registered one cycle later into
// a per-port held slot with backpressure. Misaligned or out-of-range
// addresses return rsp_err with zero data.
//
// Build option: define IMEM_ARB_RR_EN for round-robin arbitration
// (last_grant register); left undefined, port 0 has fixed priority.
`timescale 1ns/1ps
module imem_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  imem_arb_if.slave  bus
);

  logic [1:0]       slot_free;
  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic [WIDTH-1:0] gnt_addr;
  logic [WIDTH-1:0] word_idx;
  logic             addr_err;

  logic [1:0]       rsp_valid_q;
  logic [1:0]       rsp_err_q;
  logic [WIDTH-1:0] rsp_data0_q;
  logic [WIDTH-1:0] rsp_data1_q;

  // A slot draining this cycle counts as free, so a port can stream.
  // Grants are suppressed while reset is asserted.
  assign slot_free = ~rsp_valid_q | bus.rsp_ready;
  assign eligible  = bus.req_valid & slot_free & {2{reset_n}};

`ifdef IMEM_ARB_RR_EN
  logic last_grant;

  // Round-robin pick: on contention the port that did not win last time.
  always_comb begin
    grant = eligible;
    if (eligible == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  // Remember the most recent winner; reset to port 1 so port 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end
`else
  // Fixed priority pick: port 1 only when port 0 is not eligible.
  always_comb begin
    grant = 2'b00;
    if (eligible[0]) begin
      grant = 2'b01;
    end else if (eligible[1]) begin
      grant = 2'b10;
    end
  end
`endif

  assign gnt_addr = grant[1] ? bus.req_addr1 : bus.req_addr0;
  assign word_idx = {2'b00, gnt_addr[WIDTH-1:2]};
  assign addr_err = (gnt_addr[1:0] != 2'b00) || (word_idx >= WIDTH'(DEPTH));

  assign bus.req_ready = grant;
  assign bus.mem_rd_en = |grant;
  assign bus.mem_addr  = (|grant) ? word_idx : '0;

  // Response slots: load on grant, clear on consume, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 2'b00;
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_err_q[i]   <= addr_err;
        end else if (bus.rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
      if (grant[0]) begin
        rsp_data0_q <= addr_err ? '0 : bus.mem_rdata;
      end
      if (grant[1]) begin
        rsp_data1_q <= addr_err ? '0 : bus.mem_rdata;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data0 = rsp_data0_q;
  assign bus.rsp_data1 = rsp_data1_q;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port read arbiter that shares the single instruction memory between the fetch stage (port 0) and the debug/trace reader (port 1). It accepts byte-addressed read requests over valid/ready handshakes, converts them to word indices for the memory, and registers each response with a one-cycle latency. Each port has its own held response slot with backpressure. The block sits between the core front end and the instruction memory.

## Interface
- WIDTH, 32, address and instruction width
- DEPTH, 256, memory depth in words; addresses at or beyond DEPTH words are errors
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid[1:0]  in  2  per-port request valid
- req_addr0, req_addr1  in  WIDTH  per-port byte address
- req_ready[1:0]  out  2  per-port request accepted this cycle (combinational)
- rsp_valid[1:0]  out  2  per-port response valid (registered)
- rsp_data0, rsp_data1  out  WIDTH  per-port instruction word
- rsp_err[1:0]  out  2  per-port error flag, qualified by rsp_valid
- rsp_ready[1:0]  in  2  per-port response consumed
- mem_addr  out  WIDTH  word index to memory: {2'b00, granted_addr[WIDTH-1:2]}
- mem_rd_en  out  1  high in any cycle with a grant
- mem_rdata  in  WIDTH  combinational read data from memory

## Operation
- Slot free(i) = !rsp_valid[i] || rsp_ready[i]; eligible(i) = req_valid[i] && free(i).
- At most one grant per cycle, and only to an eligible port. req_ready[i] = grant[i].
- Arbitration with both ports eligible:
  - Round-robin: grant the port that is not last_grant.
  - Fixed priority: port 0 always wins.
- last_grant register: updated to the granted port on every grant; resets to 1, so port 0 wins the first contention.
- With no grant:
  - mem_addr = 0 and mem_rd_en = 0.
  - last_grant holds.
- On grant(i), at the next edge:
  - rsp_valid[i] <= 1.
  - rsp_data_i <= mem_rdata.
  - rsp_err[i] <= (addr[1:0] != 0) || (addr[WIDTH-1:2] >= DEPTH).
- If rsp_err is set, rsp_data_i <= 0 and the memory data is discarded.
- A response is consumed on rsp_valid[i] && rsp_ready[i]. If there is no new grant to that port in the same cycle, rsp_valid[i] <= 0. If there is a grant, the slot is overwritten (back-to-back).
- rsp_data/rsp_err hold stable while rsp_valid && !rsp_ready.
- rsp_ready asserted with rsp_valid low is ignored.

## Timing
- Reset (async assert, sync release on clk): rsp_valid = 0, rsp_data0/1 = 0, rsp_err = 0, last_grant = 1.
- Combinational outputs during reset: req_ready = 0, mem_rd_en = 0, mem_addr = 0.
- Latency: request accepted in cycle N → response valid in cycle N+1.
- Throughput: 1 request per cycle total; per port, 1 per cycle while that port holds rsp_ready high.
- A stalled port (rsp_valid high, rsp_ready low) receives no grant. The other port may use every cycle.
- Requester rule: req_addr is held stable while req_valid && !req_ready.
- Reset asserted mid-transaction: the in-flight response is dropped and no rsp_valid appears after release.
- Simultaneous events: both ports valid in the same cycle in which port 0 drains its slot → arbitration proceeds normally, and port 0 counts as eligible.

## Configuration
- IMEM_ARB_RR_EN defined: round-robin arbitration using last_grant, as above.
- IMEM_ARB_RR_EN undefined: fixed priority, port 0 over port 1.
  - last_grant is not implemented.
  - Port 1 is granted only when port 0 is not eligible.

## Test plan
- Single port 0 read, addr 0x0000_0008, memory word[2] = 0x0000_0513 → req_ready0 = 1 in cycle N; rsp_valid0 = 1 and rsp_data0 = 0x0000_0513 in N+1; mem_addr = 2 in N.
- Both ports valid continuously, rsp_ready = 2'b11, RR enabled → grants alternate 0,1,0,1 starting with port 0. With the macro undefined → port 0 every cycle, port 1 is never granted.
- Port 1 response held with rsp_ready1 = 0 for 5 cycles → rsp_data1 stable, req_ready1 = 0 throughout, and port 0 is granted every cycle.
- Misaligned addr 0x0000_0006 on port 0 → rsp_err0 = 1, rsp_data0 = 0. Out-of-range addr 0x0000_0400 (word 256, DEPTH = 256) → rsp_err0 = 1.
- Back-to-back port 0 reads at 0x0, 0x4, 0x8 with rsp_ready0 = 1 → rsp_valid0 high for 3 consecutive cycles, carrying words 0, 1, 2.
- reset_n pulled low in the cycle after a grant → rsp_valid = 0 immediately and stays 0 after release. The first contention after release goes to port 0.
